bus_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_arbiter_rr_picker.sv | 36 +++
 rtl/bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, arbiter state encoding and the read value
// returned on an aborted (timed-out) transaction.
package bus_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;

    // Read data handed back with m_err=1 when a transaction times out.
    localparam logic [BUS_DW-1:0] TMO_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rr_picker: round-robin masked priority encoder.
// Picks the first asserted request strictly after i_ptr, wrapping around.
//   i_req   [N-1:0]  request vector
//   i_ptr   [PW-1:0] index of the previous winner
//   o_grant [N-1:0]  one-hot winner (all zero when nothing requests)
//   o_valid          at least one request present
module rr_picker #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    // One spare bit so ptr+offset can exceed N before wrapping.
    logic [PW:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end
            if (!o_valid && i_req[w_idx[PW-1:0]]) begin
                o_grant[w_idx[PW-1:0]] = 1'b1;
                o_valid                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared tristate system bus.
// Runs one transaction at a time: IDLE (arbitrate/latch) -> WAIT (drive bus
// until slave ready) -> DONE (one bus-idle cycle, ack visible) -> IDLE.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   m_req/m_r_w    per-master request / direction (1 = write)
//   m_addr/m_wdata per-master address / write data, master i at [32i+31:32i]
//   m_grant        one-hot current owner
//   m_ack/m_err    one-cycle completion pulse / abort flag valid with ack
//   m_rdata        read data, valid in the ack cycle
//   bus_request, bus_r_w, bus_address  bus control, driven only here
//   bus_data       tristate data, driven by us only for writes in WAIT
//   bus_ready      slave one-cycle ready pulse
//
// Build option: define BUS_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles (ack with m_err=1, m_rdata=TMO_RDATA).
import bus_pkg::*;

module bus_arbiter #(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_r_w,
    input  logic [BUS_AW*N_MASTERS-1:0]   m_addr,
    input  logic [BUS_DW*N_MASTERS-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_grant,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic                          m_err,
    output logic [BUS_DW-1:0]             m_rdata,
    output logic                          bus_request,
    output logic                          bus_r_w,
    output logic [BUS_AW-1:0]             bus_address,
    inout  wire  [BUS_DW-1:0]             bus_data,
    input  logic                          bus_ready
);

    localparam int unsigned PW = $clog2(N_MASTERS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_ptr;
    logic [N_MASTERS-1:0]  r_grant;
    logic [N_MASTERS-1:0]  r_ack;
    logic                  r_err;
    logic [BUS_DW-1:0]     r_rdata;
    logic                  r_req;
    logic                  r_rw;
    logic [BUS_AW-1:0]     r_addr;
    logic [BUS_DW-1:0]     r_wdata;

    logic [N_MASTERS-1:0]  w_pick;
    logic                  w_pick_vld;
    logic [PW-1:0]         w_win_idx;
    logic [BUS_AW-1:0]     w_sel_addr;
    logic [BUS_DW-1:0]     w_sel_wdata;
    logic                  w_sel_rw;
    logic                  w_load;
    logic                  w_finish;
    logic                  w_abort;
    logic                  w_tmo_hit;

    rr_picker #(
        .N  (N_MASTERS),
        .PW (PW)
    ) u_picker (
        .i_req   (m_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_valid (w_pick_vld)
    );

    // Mux the winning master's fields from the one-hot pick.
    always_comb begin
        w_win_idx   = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_rw    = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (w_pick[i]) begin
                w_win_idx   = PW'(i);
                w_sel_addr  = m_addr[i*BUS_AW +: BUS_AW];
                w_sel_wdata = m_wdata[i*BUS_DW +: BUS_DW];
                w_sel_rw    = m_r_w[i];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Counter is 0 during the first WAIT cycle, so comparing against
    // TIMEOUT_CYCLES-1 aborts on the edge where it would reach TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst || w_load) begin
            r_tmo_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == WAIT) &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state and transaction strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A real ready wins over a coincident timeout.
                if (bus_ready) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= PW'(N_MASTERS - 1);
            r_grant <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= '0;
            if (r_state == DONE) begin
                r_err <= 1'b0;
            end
            if (w_load) begin
                r_grant <= w_pick;
                r_ptr   <= w_win_idx;
                r_addr  <= w_sel_addr;
                r_rw    <= w_sel_rw;
                r_wdata <= w_sel_wdata;
                r_req   <= 1'b1;
            end
            // Ack goes to the current owner; grant drops as the bus goes idle.
            if (w_finish || w_abort) begin
                r_ack   <= r_grant;
                r_grant <= '0;
                r_req   <= 1'b0;
                r_err   <= w_abort;
                if (w_abort) begin
                    r_rdata <= TMO_RDATA;
                end else if (r_rw) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= bus_data;
                end
            end
        end
    end

    assign bus_data    = (r_state == WAIT && r_rw) ? r_wdata : 'z;
    assign bus_request = r_req;
    assign bus_r_w     = r_rw;
    assign bus_address = r_addr;
    assign m_grant     = r_grant;
    assign m_ack       = r_ack;
    assign m_err       = r_err;
    assign m_rdata     = r_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small memory slave (64 words at
// 0x00..0x3F, ready four cycles after it first sees bus_request).
// bus_data carries a pull-up so a released bus reads as all ones.
module tb_bus_arbiter;

    localparam int unsigned N   = 2;
    localparam int unsigned TMO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_req, m_r_w;
    logic [32*N-1:0]   m_addr, m_wdata;
    logic [N-1:0]      m_grant, m_ack;
    logic              m_err;
    logic [31:0]       m_rdata;
    logic              bus_request, bus_r_w;
    logic [31:0]       bus_address;
    tri1  [31:0]       bus_data;
    logic              bus_ready;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int k;
    int n_ack;
    logic [N-1:0] ack_seen;

    always #5 clk = ~clk;

    bus_arbiter #(
        .N_MASTERS      (N),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .m_req       (m_req),
        .m_r_w       (m_r_w),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_grant     (m_grant),
        .m_ack       (m_ack),
        .m_err       (m_err),
        .m_rdata     (m_rdata),
        .bus_request (bus_request),
        .bus_r_w     (bus_r_w),
        .bus_address (bus_address),
        .bus_data    (bus_data),
        .bus_ready   (bus_ready)
    );

    // Memory slave model.
    logic [31:0] mem [64];
    logic [1:0]  s_cnt;
    bit          s_init = 1'b0;
    logic        s_hit;

    assign s_hit    = (bus_address < 32'h40);
    assign bus_data = (bus_request && !bus_r_w && s_hit) ? mem[bus_address[5:0]] : 'z;

    always @(posedge clk) begin
        if (!s_init) begin
            mem[5] <= 32'h1234_5678;
            mem[6] <= 32'h6666_0006;
            s_init <= 1'b1;
        end
        if (rst || !bus_request || !s_hit) begin
            s_cnt     <= '0;
            bus_ready <= 1'b0;
        end else if (bus_ready) begin
            bus_ready <= 1'b0;
            s_cnt     <= '0;
            if (bus_r_w) mem[bus_address[5:0]] <= bus_data;
        end else if (s_cnt == 2'd3) begin
            bus_ready <= 1'b1;
        end else begin
            s_cnt <= s_cnt + 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic rw, input logic [31:0] a, input logic [31:0] d);
        m_r_w[i]           = rw;
        m_addr[i*32 +: 32] = a;
        m_wdata[i*32 +: 32] = d;
    endtask

    // Counts negedges until an ack appears; gives up after 40.
    task automatic wait_ack(output int cnt);
        cnt = 0;
        while (m_ack == '0 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; m_req = '0; m_r_w = '0; m_addr = '0; m_wdata = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_grant",   m_grant, 0);
        chk("rst_ack",     m_ack, 0);
        chk("rst_err",     m_err, 0);
        chk("rst_rdata",   m_rdata, 0);
        chk("rst_req",     bus_request, 0);
        chk("rst_rw",      bus_r_w, 0);
        chk("rst_addr",    bus_address, 0);
        chk("rst_data_z",  bus_data, 32'hFFFF_FFFF);
        rst = 1'b0;
        @(negedge clk);

        // Single read, master 0, addr 0x05
        set_m(0, 1'b0, 32'h05, 32'h0); m_req = 2'b01;
        @(negedge clk);
        chk("rd_req_1cyc", bus_request, 1);
        chk("rd_grant",    m_grant, 2'b01);
        chk("rd_addr",     bus_address, 32'h05);
        chk("rd_rw",       bus_r_w, 0);
        wait_ack(k);
        chk("rd_latency",  k, 5);
        chk("rd_ack",      m_ack, 2'b01);
        chk("rd_data",     m_rdata, 32'h1234_5678);
        chk("rd_err",      m_err, 0);
        chk("rd_grant_clr", m_grant, 0);
        chk("rd_req_drop", bus_request, 0);
        chk("rd_data_rel", bus_data, 32'hFFFF_FFFF);
        m_req = '0;
        @(negedge clk);
        chk("rd_ack_pulse", m_ack, 0);
        chk("rd_idle_gap", bus_request, 0);

        // Single write, master 1, 0xA5A5_0001 -> 0x21
        set_m(1, 1'b1, 32'h21, 32'hA5A5_0001); m_req = 2'b10;
        @(negedge clk);
        chk("wr_req",      bus_request, 1);
        chk("wr_grant",    m_grant, 2'b10);
        chk("wr_rw",       bus_r_w, 1);
        chk("wr_addr",     bus_address, 32'h21);
        chk("wr_drive",    bus_data, 32'hA5A5_0001);
        wait_ack(k);
        chk("wr_latency",  k, 5);
        chk("wr_ack",      m_ack, 2'b10);
        chk("wr_rdata0",   m_rdata, 0);
        chk("wr_data_rel", bus_data, 32'hFFFF_FFFF);
        m_req = '0;
        @(negedge clk);

        // Read back 0x21 on master 1
        set_m(1, 1'b0, 32'h21, 32'h0); m_req = 2'b10;
        @(negedge clk);
        wait_ack(k);
        chk("rb_ack",      m_ack, 2'b10);
        chk("rb_data",     m_rdata, 32'hA5A5_0001);
        m_req = '0;
        @(negedge clk);

        // Reset asserted mid-WAIT
        set_m(0, 1'b0, 32'h05, 32'h0); m_req = 2'b01;
        repeat (3) @(negedge clk);
        chk("mid_in_wait", bus_request, 1);
        rst = 1'b1; m_req = '0;
        @(negedge clk);
        chk("mid_rst_req",   bus_request, 0);
        chk("mid_rst_grant", m_grant, 0);
        chk("mid_rst_data",  bus_data, 32'hFFFF_FFFF);
        chk("mid_rst_ack",   m_ack, 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_noack", m_ack, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Contention: both masters request continuously from reset
        set_m(0, 1'b0, 32'h05, 32'h0);
        set_m(1, 1'b0, 32'h06, 32'h0);
        m_req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            wait_ack(k);
            chk("cont_latency", k, 6);
            chk("cont_order",   m_ack, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_rdata",   m_rdata, (t % 2 == 0) ? 32'h1234_5678 : 32'h6666_0006);
            chk("cont_done_idle", bus_request, 0);
            if (t == 5) m_req = '0;
            @(negedge clk);
            chk("cont_idle_gap", bus_request, 0);
        end

        // Owner drops m_req mid-transaction
        m_req = 2'b01;
        @(negedge clk);
        chk("drop_grant", m_grant, 2'b01);
        repeat (2) @(negedge clk);
        m_req = '0;
        n_ack = 0; ack_seen = '0;
        repeat (10) begin
            @(negedge clk);
            if (m_ack != '0) begin
                n_ack++;
                ack_seen = m_ack;
            end
        end
        chk("drop_ack_count", n_ack, 1);
        chk("drop_ack_owner", ack_seen, 2'b01);

`ifdef BUS_TIMEOUT_EN
        // Unmapped read aborts after TMO wait cycles
        set_m(0, 1'b0, 32'h1000, 32'h0); m_req = 2'b01;
        wait_ack(k);
        chk("tmo_latency", k, TMO + 1);
        chk("tmo_ack",     m_ack, 2'b01);
        chk("tmo_err",     m_err, 1);
        chk("tmo_rdata",   m_rdata, 32'hDEAD_BEEF);
        set_m(1, 1'b0, 32'h21, 32'h0); m_req = 2'b10;
        @(negedge clk);
        wait_ack(k);
        chk("tmo_next_lat",  k, 6);
        chk("tmo_next_ack",  m_ack, 2'b10);
        chk("tmo_next_err",  m_err, 0);
        chk("tmo_next_data", m_rdata, 32'hA5A5_0001);
        m_req = '0;
        @(negedge clk);
`else
        // Unmapped read holds WAIT indefinitely
        set_m(0, 1'b0, 32'h1000, 32'h0); m_req = 2'b01;
        @(negedge clk);
        chk("unm_req",  bus_request, 1);
        chk("unm_addr", bus_address, 32'h1000);
        n_ack = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_ack != '0) n_ack++;
        end
        chk("unm_no_ack",  n_ack, 0);
        chk("unm_holding", bus_request, 1);
        chk("unm_err",     m_err, 0);
        rst = 1'b1; m_req = '0;
        @(negedge clk);
        chk("unm_rst_req", bus_request, 0);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
